// File: rtl/bit_serial_add_sub.sv
// Bit-serial adder/subtractor: takes one operand word through a valid/ready
// handshake, produces the sum or difference one bit per clock (LSB first),
// then presents result and flags until the downstream handshake.
//
// Ports:
//   clk, rst_n              - clock, synchronous active-low reset
//   in_valid/in_ready       - operand handshake (a, b, mode)
//   a, b [WIDTH-1:0]        - operands
//   mode                    - 0 = a+b, 1 = a-b
//   out_valid/out_ready     - result handshake
//   result [WIDTH-1:0]      - sum/difference modulo 2^WIDTH
//   carry_borrow            - carry out (add) or borrow, a<b unsigned (sub)
//   overflow                - two's-complement overflow
//   busy                    - operation in flight (CALC or DONE)
module bit_serial_add_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_borrow,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic             mode_q;
  logic             carry;
  logic             carry_msb;
  logic [CW-1:0]    cnt;

  logic             sum_bit_c;
  logic             carry_nxt_c;

  // Full adder on the current LSBs of the shifting operand registers.
  always_comb begin
    sum_bit_c   = a_q[0] ^ b_q[0] ^ carry;
    carry_nxt_c = (a_q[0] & b_q[0]) | (a_q[0] & carry) | (b_q[0] & carry);
  end

  // Control FSM and datapath. Outputs are published one cycle after
  // entering DONE, so out_valid rises WIDTH+1 edges after the accept edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      acc          <= '0;
      mode_q       <= 1'b0;
      carry        <= 1'b0;
      carry_msb    <= 1'b0;
      cnt          <= '0;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      result       <= '0;
      carry_borrow <= 1'b0;
      overflow     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a_q      <= a;
            // Subtraction is a + ~b + 1: invert b here, seed carry with mode.
            b_q      <= b ^ {WIDTH{mode}};
            mode_q   <= mode;
            carry    <= mode;
            cnt      <= '0;
            acc      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          acc   <= {sum_bit_c, acc[WIDTH-1:1]};
          carry <= carry_nxt_c;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            // Carry into the MSB, kept for the overflow flag.
            carry_msb <= carry;
            cnt       <= '0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid    <= 1'b1;
            result       <= acc;
            carry_borrow <= carry ^ mode_q;
            overflow     <= carry_msb ^ carry;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/bit_serial_add_sub.md
BIT_SERIAL_ADD_SUB -- requirements
Module: bit_serial_add_sub

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; one clock, reset is synchronous and active-low.
REQ-004 in_valid  input  1  operand word a/b/mode valid.
REQ-005 in_ready  output  1  block can accept an operand word.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 mode  input  1  0 = A+B, 1 = A-B.
REQ-009 out_valid  output  1  result, carry_borrow and overflow valid.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 result  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-012 carry_borrow  output  1  mode 0: carry out; mode 1: borrow (1 when A < B unsigned).
REQ-013 overflow  output  1  two's-complement signed overflow of the operation.
REQ-014 busy  output  1  high in CALC and DONE.

Function
REQ-015 The block SHALL implement FSM states IDLE, CALC, DONE.
REQ-016 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready, capture a, b XOR {WIDTH{mode}}, mode, set internal carry=mode, bit counter=0, go CALC.
REQ-017 CALC: one bit per cycle, LSB first: sum bit = a[i]^b'[i]^carry; carry <= majority(a[i], b'[i], carry); sum bit shifted into result register from MSB end.
REQ-018 CALC SHALL last exactly WIDTH cycles; after bit WIDTH-1 it SHALL go DONE.
REQ-019 out_valid SHALL rise exactly WIDTH+1 clock edges after the accepting edge (accept edge counted as 0).
REQ-020 On entry to DONE: carry_borrow = final carry for mode 0, NOT final carry for mode 1; overflow = carry into MSB XOR carry out of MSB.
REQ-021 DONE: out_valid=1; result, carry_borrow, overflow SHALL hold stable until out_valid&&out_ready; then go IDLE.
REQ-022 in_ready SHALL be 0 in CALC and DONE; a, b, mode, in_valid SHALL be ignored there (no capture, no effect on in-flight operation).
REQ-023 out_ready SHALL be ignored outside DONE.
REQ-024 No back-to-back overlap: next accept no earlier than the cycle after the output handshake edge.
REQ-025 Arithmetic SHALL equal (A + B) mod 2^WIDTH or (A - B) mod 2^WIDTH for all operand values, including 0, all-ones, and signed min/max.

Reset
REQ-026 While rst_n=0 at a clock edge: state=IDLE, result=0, carry_borrow=0, overflow=0, out_valid=0, busy=0, counter=0, internal carry=0.
REQ-027 in_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after release.
REQ-028 Reset asserted during CALC or DONE SHALL abort the operation with no result ever presented; no partial state retained.

Verification
REQ-029 WIDTH=8, a=0x05, b=0x03, mode=0 -> out_valid after 9 edges, result=0x08, carry_borrow=0, overflow=0.
REQ-030 a=0x03, b=0x05, mode=1 -> result=0xFE, carry_borrow=1, overflow=0; a=0x80, b=0x01, mode=1 -> result=0x7F, carry_borrow=0, overflow=1.
REQ-031 a=0xFF, b=0x01, mode=0 -> result=0x00, carry_borrow=1, overflow=0; a=0x7F, b=0x01, mode=0 -> result=0x80, carry_borrow=0, overflow=1.
REQ-032 Hold out_ready=0 for 5 cycles in DONE while toggling a/b/mode/in_valid -> outputs unchanged, in_ready=0; release -> IDLE next cycle, in_ready=1.
REQ-033 Pulse rst_n=0 for one cycle at CALC bit 4 -> all outputs 0, IDLE; new operation 0x10+0x20 -> result=0x30 with correct latency.
REQ-034 Random self-checking run, 10k operations, random in_valid/out_ready gaps, both modes -> every result/flag matches reference model; exactly one output per accepted input.
